shift_register_param: RTL and testbench
=======================================

# shift_register_param

Parameterised universal shift register with serial ports, four shift modes, and a counted-burst controller. A single `start` command loads a shift count and the register performs exactly that many one-bit shifts, one per cycle. It reports `busy` during the burst and pulses `done` at the end. It replaces the fixed 10-bit free-running right-shifter in datapath and serialiser tiles. Unlike that block, it holds its value when idle.

## Interface
- `WIDTH`, default 10: register width in bits, at least 2.
- `CNT_W`, default $clog2(WIDTH+1)+2: width of the shift-count input.
- `clk`  in  1: clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `load`  in  1: parallel load of `data_in`; honoured only when idle.
- `data_in`  in  WIDTH: parallel load data.
- `start`  in  1: begin a counted shift burst; honoured only when idle.
- `mode`  in  2: shift mode, sampled with `start`.
  - 00: logical right. 01: logical left. 10: arithmetic right. 11: rotate right.
- `count`  in  CNT_W: number of shifts in the burst, sampled with `start`.
- `ser_in`  in  1: fill bit for the vacated position, used in logical modes only.
- `data_out`  out  WIDTH: register contents.
- `ser_out`  out  1: the bit shifted out by the most recent shift.
- `busy`  out  1: high while a burst is in progress.
- `done`  out  1: one-cycle pulse when a burst completes.

## Operation
- The FSM has two states, IDLE and SHIFT. Reset state is IDLE.
- Reset values: `data_out`=0, `ser_out`=0, `busy`=0, `done`=0, internal remaining-count register=0.
- IDLE behaviour:
  - The register holds its value.
  - `load`=1: `data_out` <= `data_in`.
  - `start`=1 with `count`>0: latch `mode`, set remaining=`count`, set `busy`=1, go to SHIFT.
  - `start`=1 with `count`=0: `done` pulses at the next edge, `busy` stays 0, state stays IDLE.
- `load` and `start` in the same IDLE cycle: the load takes effect at that edge. The burst then operates on the loaded value.
- SHIFT behaviour: each edge performs one shift in the latched mode and decrements remaining. When remaining==1 the edge does the final shift, clears `busy`, sets `done`, and returns to IDLE.
- Per-mode shift rules:
  - Logical right: MSB <= `ser_in`.
  - Logical left: LSB <= `ser_in`.
  - Arithmetic right: MSB is replicated; `ser_in` is ignored.
  - Rotate right: LSB wraps to MSB; `ser_in` is ignored.
- `ser_out` takes the bit shifted out: LSB for the right modes, MSB for logical left. `ser_out` changes only on shift edges.
- `count` may exceed WIDTH.
  - Rotate wraps modulo WIDTH.
  - Logical modes fully flush to the `ser_in` fill.
  - Arithmetic right saturates to all sign bits.
- `load`, `start`, `mode` and `count` are ignored while `busy`=1. A `start` held across the end of a burst is honoured on the first IDLE cycle.
- `reset` asserted mid-burst aborts the burst. All outputs return to their reset values at that edge, and no `done` is emitted.

## Timing
- `start` is sampled at edge 0. Shifts occur at edges 1..N.
- `busy` is high after edge 0 through edge N, i.e. for N cycles.
- The final `data_out` and `done`=1 are both visible after edge N. `done` drops after edge N+1.
- The next `start` is accepted at edge N+1, giving back-to-back bursts with one idle cycle between them.
- A `load` result is visible one cycle after it is sampled.
- `count`=0: `done` is high for the cycle after edge 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- The shared package `shift_pkg` holds:
  - `shift_mode_t`, a 2-bit enum: SH_LSR, SH_LSL, SH_ASR, SH_ROR.
  - `shift_state_t`: S_IDLE, S_SHIFT.
- One sub-module, `shift_step`: a combinational single-bit shifter.
  - Inputs: value, mode, `ser_in`.
  - Outputs: next value, bit out.
- The top level holds the FSM, the remaining counter and the output registers.

## Test plan
- Reset, then idle for 5 cycles -> `data_out`=0; `busy`, `done` and `ser_out` all 0; the value holds with no drift.
- Load 0x2CE, start with mode 00, `count`=3, `ser_in`=0:
  - `busy` high for 3 cycles.
  - Then `data_out`=0x059, `ser_out`=1, and `done` pulses once.
- Load 0x2CE, start with mode 01, `count`=2, `ser_in`=1 -> `data_out`=0x33B, `ser_out`=0.
- Same-cycle `load` 0x200 and `start` with mode 10, `count`=4 -> `data_out`=0x3E0.
  - Then load 0x001 and start with mode 11, `count`=12 -> `data_out`=0x100.
- `start` with `count`=0 -> `done` pulses one cycle later, `busy` never rises, `data_out` is unchanged.
- Burst with `count`=8, and `reset` asserted after the 3rd shift -> all outputs return to 0 at that edge.
  - No `done` pulse follows.
  - A `load` or `start` issued mid-burst in a separate run is ignored.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types for the counted-burst universal shift register
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSR = 2'b00,
        SH_LSL = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shifter for the four shift modes
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] value,
    input  shift_mode_t      mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_value,
    output logic             bit_out
);

    always_comb begin
        next_value = value;
        bit_out    = 1'b0;
        case (mode)
            SH_LSR: begin
                next_value = {ser_in, value[WIDTH-1:1]};
                bit_out    = value[0];
            end
            SH_LSL: begin
                next_value = {value[WIDTH-2:0], ser_in};
                bit_out    = value[WIDTH-1];
            end
            SH_ASR: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                bit_out    = value[0];
            end
            SH_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                bit_out    = value[0];
            end
            default: begin
                next_value = value;
                bit_out    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_register_param.sv
// rtl/shift_register_param.sv - universal shift register performing counted shift bursts
module shift_register_param
    import shift_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = $clog2(WIDTH + 1) + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    shift_state_t     state;
    shift_mode_t      mode_r;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] step_value;
    logic             step_bit;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value     (data_out),
        .mode      (mode_r),
        .ser_in    (ser_in),
        .next_value(step_value),
        .bit_out   (step_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_r    <= SH_LSR;
            remaining <= '0;
            data_out  <= '0;
            ser_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A same-cycle load lands first; the burst then shifts the loaded value.
                    if (load) begin
                        data_out <= data_in;
                    end
                    if (start) begin
                        if (count != '0) begin
                            mode_r    <= shift_mode_t'(mode);
                            remaining <= count;
                            busy      <= 1'b1;
                            state     <= S_SHIFT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    data_out  <= step_value;
                    ser_out   <= step_bit;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register_param.sv
// tb/tb_shift_register_param.sv - scoreboard bench for shift_register_param
module tb_shift_register_param;

    localparam int W  = 10;
    localparam int CW = 6;

    typedef struct {
        string      tag;
        logic [W-1:0] data;
        logic       ser;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [W-1:0]  data_in;
    logic          start;
    logic [1:0]    mode;
    logic [CW-1:0] count;
    logic          ser_in;
    logic [W-1:0]  data_out;
    logic          ser_out;
    logic          busy;
    logic          done;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    logic [W-1:0] m_data;
    logic         m_ser;

    shift_register_param dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data_in (data_in),
        .start   (start),
        .mode    (mode),
        .count   (count),
        .ser_in  (ser_in),
        .data_out(data_out),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [W-1:0] v_in, input logic [1:0] m, input int n,
                                  input logic si, input logic s_in,
                                  output logic [W-1:0] v_out, output logic s_out);
        logic [W-1:0] v;
        logic         s;
        v = v_in;
        s = s_in;
        for (int i = 0; i < n; i++) begin
            case (m)
                2'b00: begin s = v[0];   v = (v >> 1) | (W'(si) << (W-1)); end
                2'b01: begin s = v[W-1]; v = (v << 1) | W'(si); end
                2'b10: begin s = v[0];   v = (v >> 1) | (v & (W'(1) << (W-1))); end
                default: begin s = v[0]; v = (v >> 1) | (W'(v[0]) << (W-1)); end
            endcase
        end
        v_out = v;
        s_out = s;
    endfunction

    task automatic burst(input string tag, input logic [W-1:0] ld, input bit same_cycle,
                         input logic [1:0] m, input int n, input logic si,
                         input logic [W-1:0] exp_d, input logic exp_s, input bit interfere);
        int   busy_cycles;
        bit   done_seen;
        exp_t e;
        if (!same_cycle) begin
            load = 1'b1; data_in = ld;
            tick();
            load = 1'b0;
            check({tag, "_load"}, data_out, ld);
        end else begin
            load = 1'b1; data_in = ld;
        end
        start = 1'b1; mode = m; count = CW'(n); ser_in = si;
        sb_q.push_back('{tag: tag, data: exp_d, ser: exp_s});
        m_data = exp_d;
        m_ser  = exp_s;
        tick();
        start = 1'b0; load = 1'b0;
        busy_cycles = 0;
        done_seen   = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (interfere && busy_cycles == 2) begin
                load = 1'b1; data_in = '1; start = 1'b1; mode = 2'b01; count = CW'(1);
            end
            tick();
            load = 1'b0; start = 1'b0;
        end
        check({tag, "_done_seen"}, done_seen, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_data"}, data_out, e.data);
            check({e.tag, "_ser"}, ser_out, e.ser);
        end
        check({tag, "_busy_cycles"}, busy_cycles, n);
        check({tag, "_busy_end"}, busy, 0);
        tick();
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_hold"}, data_out, exp_d);
    endtask

    initial begin
        logic [W-1:0] rv, ed;
        logic [1:0]   rm;
        logic         rs, es;
        int           rn, done_cnt;

        reset = 1'b1; load = 1'b0; data_in = '0; start = 1'b0;
        mode = 2'b00; count = '0; ser_in = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_data", data_out, 0);
            check("idle_flags", {busy, done, ser_out}, 0);
        end

        burst("lsr3", 10'h2CE, 1'b0, 2'b00, 3, 1'b0, 10'h059, 1'b1, 1'b0);
        burst("lsl2", 10'h2CE, 1'b0, 2'b01, 2, 1'b1, 10'h33B, 1'b0, 1'b0);
        burst("asr4_same", 10'h200, 1'b1, 2'b10, 4, 1'b0, 10'h3E0, 1'b0, 1'b0);
        burst("ror12", 10'h001, 1'b0, 2'b11, 12, 1'b0, 10'h100, 1'b0, 1'b0);

        // count=0: no load, data and ser_out must stay where the previous burst left them
        start = 1'b1; count = '0; mode = 2'b00;
        tick();
        start = 1'b0;
        check("cnt0_done", done, 1);
        check("cnt0_busy", busy, 0);
        check("cnt0_data", data_out, 10'h100);
        tick();
        check("cnt0_done_drop", done, 0);
        check("cnt0_busy2", busy, 0);

        burst("lsr_flush", 10'h3FF, 1'b0, 2'b00, 14, 1'b1, 10'h3FF, 1'b1, 1'b0);
        burst("asr_sat", 10'h2AA, 1'b0, 2'b10, 15, 1'b0, 10'h3FF, 1'b1, 1'b0);
        burst("ignore_mid", 10'h155, 1'b0, 2'b00, 4, 1'b0, 10'h015, 1'b0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            rv = W'($urandom);
            rm = 2'($urandom_range(0, 3));
            rn = $urandom_range(1, 15);
            rs = 1'($urandom);
            model(rv, rm, rn, rs, 1'b0, ed, es);
            burst("rand", rv, 1'b0, rm, rn, rs, ed, es, 1'b0);
        end

        // reset during a burst after the third shift
        load = 1'b1; data_in = 10'h2CE;
        tick();
        load = 1'b0;
        start = 1'b1; mode = 2'b11; count = CW'(8);
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_data", data_out, 0);
        check("rst_flags", {busy, done, ser_out}, 0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);
        check("rst_hold", data_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
